// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - fetch/decode handshake bundle for the fetch queue
interface fetch_queue_if #(
  parameter int XLEN  = 64,
  parameter int ILEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic            Valid_F;
  logic [XLEN-1:0] PC_F;
  logic [ILEN-1:0] Instr_F;
  logic            Ready_F;
  logic            Flush;
  logic            Stall_D;
  logic            Valid_D;
  logic [XLEN-1:0] PC_D;
  logic [ILEN-1:0] Instr_D;
  logic [CW-1:0]   Count;

  modport master (
    output Valid_F, PC_F, Instr_F, Flush, Stall_D,
    input  Ready_F, Valid_D, PC_D, Instr_D, Count
  );

  modport slave (
    input  Valid_F, PC_F, Instr_F, Flush, Stall_D,
    output Ready_F, Valid_D, PC_D, Instr_D, Count
  );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - circular instruction queue between fetch and decode
module fetch_queue #(
  parameter int              XLEN  = 64,
  parameter int              ILEN  = 32,
  parameter int              DEPTH = 4,
  parameter logic [ILEN-1:0] NOP   = 32'h00000013
) (
  input  logic         clk,
  input  logic         rst,
  fetch_queue_if.slave q
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fetch_queue: DEPTH must be a power of two and at least 2");
  end

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [ILEN-1:0] instr_mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic            full;
  logic            valid;
  logic            push;
  logic            pop;

  // Ready ignores Stall_D so decode never combinationally gates fetch.
  assign full  = (count == CW'(DEPTH));
  assign valid = (count != '0);
  assign push  = q.Valid_F & ~full & ~q.Flush;
  assign pop   = valid & ~q.Stall_D & ~q.Flush;

  assign q.Ready_F = ~full;
  assign q.Valid_D = valid;
  assign q.PC_D    = valid ? pc_mem[rd_ptr] : '0;
  assign q.Instr_D = valid ? instr_mem[rd_ptr] : NOP;
  assign q.Count   = count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (q.Flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Payload storage carries no reset; slots are only read below count.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= q.PC_F;
      instr_mem[wr_ptr] <= q.Instr_F;
    end
  end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised instruction queue between the fetch stage and the decode stage. It is the successor to the single-entry IF/ID register: it buffers up to DEPTH fetched {PC, instruction} pairs.
- It decouples fetch from decode stalls and discards all buffered entries on a branch/jump redirect.
- When the queue is empty, decode receives a NOP bubble.

Parameters:
- XLEN, 64, PC width in bits.
- ILEN, 32, instruction width in bits.
- DEPTH, 4, number of entries. Must be a power of two and at least 2; an illegal value is an elaboration error.
- NOP, 32'h00000013, instruction word presented when no valid entry exists (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- Valid_F  in  1  fetch presents a valid instruction this cycle.
- PC_F  in  XLEN  PC of the presented instruction.
- Instr_F  in  ILEN  presented instruction word.
- Ready_F  out  1  queue can accept a push this cycle.
- Flush  in  1  redirect (PCSrc_E); discard all entries.
- Stall_D  in  1  decode cannot accept an instruction this cycle.
- Valid_D  out  1  head entry is valid.
- PC_D  out  XLEN  head PC.
- Instr_D  out  ILEN  head instruction, or NOP when Valid_D=0.
- Count  out  $clog2(DEPTH+1)  number of occupied entries.

Behaviour:
- Reset (rst=0, asynchronous):
  - read and write pointers = 0, Count = 0.
  - Valid_D = 0, PC_D = 0, Instr_D = NOP, Ready_F = 1.
  - Entry storage need not be reset.
- Storage: circular buffer of DEPTH entries. Pointers are $clog2(DEPTH) bits wide and wrap from DEPTH-1 to 0. Count is tracked explicitly.
- Push = Valid_F & Ready_F & ~Flush.
- Pop = Valid_D & ~Stall_D & ~Flush.
- Ready_F = (Count != DEPTH). It does not depend on Stall_D, so there is no combinational path from decode to fetch. When full, no push occurs even if a pop happens in the same cycle.
- Outputs are combinational from the head entry:
  - Valid_D = (Count != 0).
  - PC_D = head PC when valid, else 0.
  - Instr_D = head instruction when valid, else NOP.
- Latency: an instruction pushed at edge N appears on Valid_D/PC_D/Instr_D after edge N, i.e. the queue adds one cycle from fetch to decode. There is no same-cycle bypass.
- Count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop, including when Count = 1: the head is replaced by the next entry and the new entry is appended.
- Ordering: strict FIFO; entries are never reordered or duplicated.
- Flush has priority over push and pop in the same cycle. At the next edge:
  - Count = 0 and the pointers are reset to 0.
  - The instruction presented on Instr_F during the Flush cycle is dropped.
  - Valid_D = 0 on the following cycle.
- Stall_D=1 with Valid_D=1: the head is held and PC_D/Instr_D are unchanged. Pushes continue until Count reaches DEPTH.
- Stall_D=1 with Valid_D=0: no effect; NOP is presented.
- Valid_F=1 while full: the push is refused (Ready_F=0). Fetch must hold its PC; the queue never overwrites.
- Entries are never read past Count and never written while full, so no overflow or underflow is possible.
- Reset asserted mid-operation: all state clears immediately (asynchronous) and in-flight entries are lost. After release, the first rising edge may accept a push.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, release, Valid_F=0 -> Valid_D=0, Instr_D=32'h00000013, PC_D=0, Count=0, Ready_F=1.
- Streaming: push PC 0x0,0x4,0x8,0xC on consecutive cycles, Stall_D=0 -> Instr_D follows each one a cycle later in order; Count stays 1; no drops.
- Fill/backpressure: Stall_D=1, push 5 instructions (PCs 0x100..0x110) -> Count reaches 4, Ready_F=0, the fifth is not accepted. Release Stall_D -> 0x100,0x104,0x108,0x10C are popped in order and Ready_F returns to 1 after the first pop.
- Wrap-around: 10 push/pop cycles with a random Stall_D pattern at DEPTH=4 -> the output sequence equals the input sequence, verified against a scoreboard across pointer wrap.
- Flush priority: Count=3, assert Flush with Valid_F=1 (PC 0x200) and Stall_D=0 -> next cycle Count=0, Valid_D=0, Instr_D=NOP, and 0x200 is never output. A push of PC 0x300 in the following cycle appears next.
- Async reset mid-fill: Count=2, drop rst between edges -> Count=0 and Valid_D=0 immediately without a clock edge. Repeat the streaming scenario with DEPTH=8, XLEN=32 to cover parametrisation.
